seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Display-side consumer of the stopwatch counter's four BCD digits (min1, min0, sec1, sec0). Snapshots the digits once per scan frame, time-multiplexes them onto a 4-digit common-anode seven-segment display, and blinks the digit pair under adjustment. Sits between the counter block and the board pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit is driven per scan step. Must be at least 2.
- `BLINK_DIV`, 25000000: clock cycles per blink half-period. Must be at least 2.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `min1`, `min0`, `sec1`, `sec0`  in  4 each  BCD digits from the counter.
- `adjust`  in  2  adjust mode. Any nonzero value enables blinking.
- `select`  in  1  pair to blink: 0 = minutes, 1 = seconds.
- `an`  out  4  active-low anodes: an[0]=sec0 (rightmost), an[1]=sec1, an[2]=min0, an[3]=min1.
- `seg`  out  7  active-low cathodes: seg[0]=a … seg[6]=g.
- `dp`  out  1  active-low decimal point.

## Operation
- **Refresh counter `rc`:** counts 0..REFRESH_DIV-1. At terminal, `rc` goes to 0 and digit index `idx` (2 bits) increments, wrapping 3→0.
- **Scan order:** idx 0,1,2,3 = sec0, sec1, min0, min1.
- **Snapshot register `snap` (16 bits):**
  - Loads {min1,min0,sec1,sec0} on every cycle that reset is high.
  - Loads again on the cycle where `rc` is terminal and `idx`==3, so a frame never mixes old and new digits.
  - Input changes at any other time are ignored until the next frame boundary.
- **Decode (active-low {g..a}), digit → seg:**
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19
  - 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10
  - 10–15 → 7'h7F (blank). Non-BCD input is not an error.
- **dp:** driven 0 (lit) only while idx==2, as the minutes/seconds separator. Otherwise 1.
- **Blink counter `bc`:** counts 0..BLINK_DIV-1. At terminal, `bc` goes to 0 and `blink_phase` toggles. It runs regardless of `adjust`.
- **Blank condition:** adjust≠0, blink_phase==1, and the current idx belongs to the selected pair (select=0: idx 2,3; select=1: idx 0,1).
  - While blanked: an=4'hF, seg=7'h7F, dp=1.
  - The scan continues unchanged underneath.
- **Mid-frame input changes:** a change of `adjust` or `select` takes effect on the next output register update. No resync.

## Timing
- **Registered outputs:** an, seg, dp are registered from current idx, snap, blink_phase and adjust/select. They lag idx by 1 cycle.
- **Reset values:** while reset is sampled high, all state clears: rc=0, idx=0, bc=0, blink_phase=0, an=4'hF, seg=7'h7F, dp=1.
- **First edge after reset:** the first edge with reset low gives an=4'b1110 and seg=decode(snap sec0).
- **Per-digit dwell:** each digit is held exactly REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- **Anode overlap:** at most one anode is low in any cycle. Anodes never overlap.
- **Snapshot latency:** a new snapshot is first displayed (idx 0) on the edge after the snapshot load.
- **Reset mid-frame:** the scan restarts at idx 0 and blink_phase restarts at 0 (visible).

## Structure
- **Shared package `stopwatch_pkg`:**
  - the ten segment constants plus the blank value;
  - digit index constants (IDX_SEC0..IDX_MIN1);
  - select encodings (SEL_MIN=0, SEL_SEC=1).
- **Sub-module `bcd_to_seg7`:** combinational 4-bit → 7-bit decoder, instantiated once on the muxed digit.
- **Counter widths:** `$clog2` of the respective divider.

## Test plan
All scenarios use REFRESH_DIV=4, BLINK_DIV=16.
- **Reset and first frame:** reset 3 cycles with inputs 1,2,3,4 (min1..sec0), release. First edge gives an=1110, seg=7'h19. After 4 cycles an=1101, seg=7'h30. Then an=1011, seg=7'h24, dp=0. Then an=0111, seg=7'h79.
- **Snapshot atomicity:** change sec0 from 4 to 7 while idx=1. Digit 0 still shows 7'h19 until the frame boundary; the next frame shows 7'h78 at an=1110.
- **Blink minutes:** adjust=2'b01, select=0. For 16 cycles all digits display normally. For the next 16, idx 2/3 slots show an=1111, seg=7'h7F while idx 0/1 display normally.
- **Blink seconds / adjust off:** select=1 blanks only idx 0/1 slots during phase 1. adjust=0 blanks nothing in either phase.
- **Non-BCD blank:** min1=4'hC gives seg=7'h7F with an=0111 asserted during the idx 3 slot.
- **Reset mid-frame:** assert reset at idx=2, blink_phase=1. The output clears next edge. After release: idx 0, blink_phase 0, and the snapshot equals the inputs present during reset.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment patterns (active-low {g..a}),
// scan digit indices and blink pair encodings.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] IDX_SEC0 = 2'd0;
  localparam logic [1:0] IDX_SEC1 = 2'd1;
  localparam logic [1:0] IDX_MIN0 = 2'd2;
  localparam logic [1:0] IDX_MIN1 = 2'd3;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  localparam logic [3:0] AN_OFF = 4'hF;

  // One registered display word: anodes, cathodes and decimal point, all active-low.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-low {g..a}.
// Codes 10..15 decode to a dark digit rather than an error.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: snapshots the BCD digits once per frame,
// multiplexes them onto the display and blinks the pair under adjustment.
module seg7_scan_driver
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [1:0] adjust,
  input  logic       select,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int BC_W = $clog2(BLINK_DIV);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

  logic [RC_W-1:0] rc;
  logic [BC_W-1:0] bc;
  logic [1:0]      idx;
  logic            blink_phase;
  logic [15:0]     snap;
  disp_t           disp;

  logic            rc_tc;
  logic            bc_tc;
  logic [3:0]      digit;
  logic [6:0]      digit_seg;
  logic            in_pair;
  logic            blank;
  disp_t           disp_next;

  assign rc_tc = (rc == RC_LAST);
  assign bc_tc = (bc == BC_LAST);

  always_comb begin
    digit = snap[3:0];
    case (idx)
      IDX_SEC0: digit = snap[3:0];
      IDX_SEC1: digit = snap[7:4];
      IDX_MIN0: digit = snap[11:8];
      IDX_MIN1: digit = snap[15:12];
      default:  digit = snap[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (digit),
    .seg   (digit_seg)
  );

  // Blanking only masks the outputs; idx and snap keep advancing underneath.
  always_comb begin
    in_pair = 1'b0;
    if (select == SEL_SEC) in_pair = (idx == IDX_SEC0) || (idx == IDX_SEC1);
    else                   in_pair = (idx == IDX_MIN0) || (idx == IDX_MIN1);
    blank = (adjust != 2'b00) && blink_phase && in_pair;
  end

  always_comb begin
    disp_next = DISP_OFF;
    if (!blank) begin
      disp_next.an  = anode_for(idx);
      disp_next.seg = digit_seg;
      disp_next.dp  = (idx != IDX_MIN0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rc          <= '0;
      idx         <= IDX_SEC0;
      bc          <= '0;
      blink_phase <= 1'b0;
      snap        <= {min1, min0, sec1, sec0};
      disp        <= DISP_OFF;
    end else begin
      if (rc_tc) begin
        rc  <= '0;
        idx <= idx + 2'd1;
        // Reload only at the frame boundary so one frame never mixes old and new digits.
        if (idx == IDX_MIN1) snap <= {min1, min0, sec1, sec0};
      end else begin
        rc <= rc + RC_W'(1);
      end

      if (bc_tc) begin
        bc          <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bc <= bc + BC_W'(1);
      end

      disp <= disp_next;
    end
  end

  assign an  = disp.an;
  assign seg = disp.seg;
  assign dp  = disp.dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=16.
module tb_seg7_scan_driver;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] min1 = 4'd0;
  logic [3:0] min0 = 4'd0;
  logic [3:0] sec1 = 4'd0;
  logic [3:0] sec0 = 4'd0;
  logic [1:0] adjust = 2'b00;
  logic       select = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .min1   (min1),
    .min0   (min0),
    .sec1   (sec1),
    .sec0   (sec0),
    .adjust (adjust),
    .select (select),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [11:0] exp_q[$];
  logic [6:0]  seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [15:0] m_snap = 16'h0000;
  logic [15:0] vecs [0:2] = '{16'h6803, 16'hBE59, 16'h7654};

  // driver: predicts the output word for the coming edge from cycles since reset release
  task automatic tick();
    logic [11:0] e;
    int          slot;
    logic        phase;
    logic        blank;
    if (reset) begin
      e      = {4'hF, 7'h7F, 1'b1};
      m_snap = {min1, min0, sec1, sec0};
      n      = 0;
    end else begin
      slot  = (n / 4) % 4;
      phase = ((n / 16) % 2) == 1;
      blank = (adjust != 2'b00) && phase && (select ? (slot < 2) : (slot >= 2));
      if (blank) e = {4'hF, 7'h7F, 1'b1};
      else       e = {~(4'b0001 << slot), seg_tab[m_snap[slot*4 +: 4]], (slot != 2)};
      if (n % 16 == 15) m_snap = {min1, min0, sec1, sec0};
      n++;
    end
    @(posedge clk);
    exp_q.push_back(e);
    pushed++;
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
               name, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
    end
  endtask

  task automatic set_digits(input logic [15:0] d);
    {min1, min0, sec1, sec0} = d;
  endtask

  // monitor: one output word per clock, compared on the falling edge
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped++;
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL scan t=%0t got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 $time, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    // reset and first frame (n=0..15)
    set_digits(16'h1234);
    reset = 1'b1;
    repeat (3) tick();
    check("reset_out", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    reset = 1'b0;
    tick();           check("first_sec0", {an, seg, dp}, {4'b1110, 7'h19, 1'b1});
    repeat (4) tick(); check("first_sec1", {an, seg, dp}, {4'b1101, 7'h30, 1'b1});
    repeat (4) tick(); check("first_min0", {an, seg, dp}, {4'b1011, 7'h24, 1'b0});
    repeat (4) tick(); check("first_min1", {an, seg, dp}, {4'b0111, 7'h79, 1'b1});
    repeat (3) tick();

    // snapshot atomicity: sec0 changes while idx=1 of frame 1
    tick();           check("old_sec0", {an, seg, dp}, {4'b1110, 7'h19, 1'b1});
    repeat (4) tick();
    sec0 = 4'd7;
    repeat (11) tick();

    // blink minutes, frames 2-3
    adjust = 2'b01;
    select = 1'b0;
    tick();           check("new_sec0", {an, seg, dp}, {4'b1110, 7'h78, 1'b1});
    repeat (15) tick();
    tick();           check("blinkmin_sec0", {an, seg, dp}, {4'b1110, 7'h78, 1'b1});
    repeat (7) tick();
    tick();           check("blinkmin_min0", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    repeat (7) tick();

    // blink seconds, frames 4-5
    select = 1'b1;
    repeat (16) tick();
    tick();           check("blinksec_sec0", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    repeat (7) tick();
    tick();           check("blinksec_min0", {an, seg, dp}, {4'b1011, 7'h24, 1'b0});
    repeat (7) tick();

    // adjust off, frames 6-7
    adjust = 2'b00;
    repeat (16) tick();
    tick();           check("noadj_sec0", {an, seg, dp}, {4'b1110, 7'h78, 1'b1});
    repeat (15) tick();

    // non-BCD minutes digit, loaded mid-frame 8, shown in frame 9
    repeat (5) tick();
    set_digits(16'hC905);
    repeat (7) tick();
    tick();           check("held_min1", {an, seg, dp}, {4'b0111, 7'h79, 1'b1});
    repeat (3) tick();
    tick();           check("sec0_five", {an, seg, dp}, {4'b1110, 7'h12, 1'b1});
    repeat (11) tick();
    tick();           check("nonbcd_min1", {an, seg, dp}, {4'b0111, 7'h7F, 1'b1});
    repeat (3) tick();

    // directed digit vectors, each applied mid-frame (frames 10-13)
    for (int i = 0; i < 3; i++) begin
      repeat (5) tick();
      set_digits(vecs[i]);
      repeat (11) tick();
    end
    repeat (32) tick();

    // reset mid-frame at idx=2 with blink_phase=1 (frame 15)
    adjust = 2'b01;
    select = 1'b1;
    repeat (8) tick();
    tick();           check("pre_reset_min0", {an, seg, dp}, {4'b1011, 7'h02, 1'b0});
    set_digits(16'h5907);
    reset = 1'b1;
    tick();           check("reset_mid", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    tick();
    reset = 1'b0;
    set_digits(16'h1111);
    tick();           check("post_reset_sec0", {an, seg, dp}, {4'b1110, 7'h78, 1'b1});
    repeat (7) tick();
    tick();           check("post_reset_min0", {an, seg, dp}, {4'b1011, 7'h10, 1'b0});
    repeat (7) tick();
    tick();           check("post_reset_blink", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    repeat (31) tick();

    // drain scoreboard
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain got popped=%0d want pushed=%0d", popped, pushed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
